// File: rtl/int_seq_pkg.sv
// Shared definitions for the interrupt/reset sequencer: FSM states, service kinds,
// status-register bit positions and the default vector/stack addresses.
package int_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_PCH = 3'd1,
        ST_PUSH_PCL = 3'd2,
        ST_PUSH_P   = 3'd3,
        ST_VEC_LO   = 3'd4,
        ST_VEC_HI   = 3'd5,
        ST_VEC_LD   = 3'd6
    } state_t;

    localparam logic [1:0] KIND_RESET = 2'd0;
    localparam logic [1:0] KIND_NMI   = 2'd1;
    localparam logic [1:0] KIND_IRQ   = 2'd2;
    localparam logic [1:0] KIND_BRK   = 2'd3;

    localparam int P_NEG    = 7;
    localparam int P_OVF    = 6;
    localparam int P_UNUSED = 5;
    localparam int P_BRK    = 4;
    localparam int P_DEC    = 3;
    localparam int P_INT    = 2;
    localparam int P_ZERO   = 1;
    localparam int P_CARRY  = 0;

    localparam logic [15:0] VEC_NMI_ADDR   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET_ADDR = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_ADDR   = 16'hFFFE;
    localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;

    // Status byte as it lands on the stack: bit 5 always reads back set, B marks BRK.
    function automatic logic [7:0] push_status(input logic [7:0] p, input logic is_brk);
        logic [7:0] r;
        r           = p;
        r[P_UNUSED] = 1'b1;
        r[P_BRK]    = is_brk;
        return r;
    endfunction

endpackage

// File: rtl/int_edge_det.sv
// NMI falling-edge detector with a pending latch; a new edge wins over a same-cycle clear.
// Edge to pending: one cycle. No backpressure; pending holds until cleared.
module int_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic nmi_n,
    input  logic clr,
    output logic pending
);

    logic nmi_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_n_q <= 1'b1;
            pending <= 1'b0;
        end else begin
            nmi_n_q <= nmi_n;
            if (nmi_n_q && !nmi_n) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/int_seq.sv
// 6502 interrupt/reset entry sequencer: pushes PC/P, fetches the vector, hands back PC/S.
// Six cycles from accept to pc_load; the core stalls while busy is high.
module int_seq
    import int_seq_pkg::*;
#(
    parameter logic [15:0] VEC_NMI    = VEC_NMI_ADDR,
    parameter logic [15:0] VEC_RESET  = VEC_RESET_ADDR,
    parameter logic [15:0] VEC_IRQ    = VEC_IRQ_ADDR,
    parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boundary,
    input  logic        brk_req,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        irq_mask,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  s_in,
    input  logic [7:0]  rd_data,
    output logic [15:0] address,
    output logic [7:0]  wr_data,
    output logic        we,
    output logic        busy,
    output logic [15:0] pc_out,
    output logic        pc_load,
    output logic [7:0]  s_out,
    output logic        s_load,
    output logic        set_i,
    output logic [1:0]  kind
);

    state_t      state, state_nxt;
    logic        reset_pending;
    logic        nmi_pending;
    logic        nmi_clr;
    logic        take;
    logic [1:0]  take_kind;
    logic [15:0] vec_sel;
    logic        push_st;

    logic [1:0]  kind_q;
    logic [15:0] pc_q;
    logic [7:0]  p_q;
    logic [7:0]  s_q;
    logic [15:0] vec_q;
    logic [7:0]  lo_q;

    int_edge_det u_edge (
        .clk     (clk),
        .reset   (reset),
        .nmi_n   (nmi_n),
        .clr     (nmi_clr),
        .pending (nmi_pending)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        take_kind = KIND_RESET;
        nmi_clr   = 1'b0;
        vec_sel   = VEC_IRQ;
        address   = 16'h0000;
        wr_data   = 8'h00;
        we        = 1'b0;
        pc_out    = 16'h0000;
        pc_load   = 1'b0;
        s_load    = 1'b0;
        set_i     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (reset_pending) begin
                    take      = 1'b1;
                    take_kind = KIND_RESET;
                end else if (boundary) begin
                    if (nmi_pending) begin
                        take      = 1'b1;
                        take_kind = KIND_NMI;
                        nmi_clr   = 1'b1;
                    end else if (!irq_n && !irq_mask) begin
                        take      = 1'b1;
                        take_kind = KIND_IRQ;
                    end else if (brk_req) begin
                        take      = 1'b1;
                        take_kind = KIND_BRK;
                    end
                end
                if (take) begin
                    state_nxt = ST_PUSH_PCH;
                end
            end
            ST_PUSH_PCH: begin
                address   = {STACK_PAGE, s_q};
                wr_data   = pc_q[15:8];
                we        = (kind_q != KIND_RESET);
                state_nxt = ST_PUSH_PCL;
            end
            ST_PUSH_PCL: begin
                address   = {STACK_PAGE, s_q};
                wr_data   = pc_q[7:0];
                we        = (kind_q != KIND_RESET);
                state_nxt = ST_PUSH_P;
            end
            ST_PUSH_P: begin
                address   = {STACK_PAGE, s_q};
                wr_data   = push_status(p_q, kind_q == KIND_BRK);
                we        = (kind_q != KIND_RESET);
                state_nxt = ST_VEC_LO;
                // An NMI arriving after IRQ/BRK was accepted steals its vector fetch.
                case (kind_q)
                    KIND_RESET: vec_sel = VEC_RESET;
                    KIND_NMI:   vec_sel = VEC_NMI;
                    default: begin
                        if (nmi_pending) begin
                            vec_sel = VEC_NMI;
                            nmi_clr = 1'b1;
                        end else begin
                            vec_sel = VEC_IRQ;
                        end
                    end
                endcase
            end
            ST_VEC_LO: begin
                address   = vec_q;
                state_nxt = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                address   = vec_q + 16'd1;
                state_nxt = ST_VEC_LD;
            end
            ST_VEC_LD: begin
                pc_out    = {rd_data, lo_q};
                pc_load   = 1'b1;
                s_load    = 1'b1;
                set_i     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign push_st = (state == ST_PUSH_PCH) || (state == ST_PUSH_PCL) || (state == ST_PUSH_P);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reset_pending <= 1'b1;
            kind_q        <= KIND_RESET;
            pc_q          <= 16'h0000;
            p_q           <= 8'h00;
            s_q           <= 8'h00;
            vec_q         <= 16'h0000;
            lo_q          <= 8'h00;
        end else begin
            if (take) begin
                if (take_kind == KIND_RESET) begin
                    reset_pending <= 1'b0;
                end
                kind_q <= take_kind;
                pc_q   <= pc_in;
                p_q    <= p_in;
                s_q    <= s_in;
            end
            // Reset still walks S down by three even though its pushes are reads.
            if (push_st) begin
                s_q <= s_q - 8'd1;
            end
            if (state == ST_PUSH_P) begin
                vec_q <= vec_sel;
            end
            if (state == ST_VEC_HI) begin
                lo_q <= rd_data;
            end
        end
    end

    assign busy  = reset_pending || (state != ST_IDLE);
    assign s_out = s_q;
    assign kind  = kind_q;

endmodule

// File: doc/int_seq.md
Name: int_seq

Overview:
- Interrupt/reset sequencer for the 6502 core. It owns the memory bus during RESET, NMI, IRQ and BRK entry.
- It pushes PCH, PCL and P to the stack, fetches the vector, then hands the core a new PC, S and the I-flag set.
- It sits beside proc and is muxed onto address/wr_data/we while busy=1.
- Memory is synchronous: rd_data is valid the cycle after address is presented, the same pipelining the core uses.

Parameters:
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RESET, 16'hFFFC, reset vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address
- STACK_PAGE, 8'h01, stack high address byte

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- boundary  in  1  core is at an instruction boundary; requests may be accepted this cycle
- brk_req  in  1  core decoded BRK; qualified by boundary
- nmi_n  in  1  NMI line, falling-edge sensitive, already synchronous to clk
- irq_n  in  1  IRQ line, level-sensitive, active-low
- irq_mask  in  1  P[I] from core
- pc_in  in  16  return PC to push; the core supplies PC+2 for BRK
- p_in  in  8  status register to push
- s_in  in  8  current stack pointer (low byte)
- rd_data  in  8  memory read data
- address  out  16  memory address while busy
- wr_data  out  8  memory write data
- we  out  1  memory write strobe
- busy  out  1  sequencer owns the bus; core stalls
- pc_out  out  16  vector fetched
- pc_load  out  1  one-cycle pulse: core loads pc_out into PC
- s_out  out  8  stack pointer after pushes
- s_load  out  1  one-cycle pulse with pc_load
- set_i  out  1  one-cycle pulse with pc_load: core sets P[I]
- kind  out  2  service in progress: 0 RESET, 1 NMI, 2 IRQ, 3 BRK

Behaviour:
- **Reset values:** state=IDLE, reset_pending=1, nmi_pending=0, nmi_n_q=1, address=0, wr_data=0, we=0, pc_load=0, s_load=0, set_i=0, kind=0, busy=1.
- **Reset mid-sequence:** aborts immediately; no further writes occur.
- **Outputs:** Moore-decoded from registered state. busy = reset_pending | (state != IDLE).
- **States:** IDLE -> PUSH_PCH -> PUSH_PCL -> PUSH_P -> VEC_LO -> VEC_HI -> VEC_LD -> IDLE. One cycle each; 6 cycles from accept to pc_load.
- **Accept in IDLE:**
  - reset_pending is accepted without boundary.
  - All other kinds need boundary=1.
  - Priority: RESET > NMI (nmi_pending) > IRQ (!irq_n & !irq_mask) > BRK (brk_req).
  - On accept: latch kind, pc_in, p_in, s_in into internal s; clear reset_pending or nmi_pending.
  - boundary with nothing to serve: stay IDLE.
- **NMI edge detect:**
  - nmi_n_q <= nmi_n each cycle.
  - nmi_pending set when nmi_n_q=1 & nmi_n=0, in any state.
  - An edge and a clear in the same cycle leave pending=1.
- **Push states:**
  - address = {STACK_PAGE, s}; s decrements after each push; 8'h00 wraps to 8'hFF.
  - PUSH_PCH writes pc[15:8], PUSH_PCL writes pc[7:0].
  - PUSH_P writes p with bit5=1 and bit4 = (kind==BRK).
  - For RESET, we=0 in all three push states (dummy reads) but s still decrements by 3.
- **Vector select at VEC_LO entry:**
  - RESET uses VEC_RESET, NMI uses VEC_NMI, IRQ/BRK use VEC_IRQ.
  - NMI hijack: if nmi_pending=1 when leaving PUSH_P and kind is IRQ or BRK, use VEC_NMI and clear nmi_pending. The pushed B bit is unchanged and kind stays IRQ/BRK.
- **Vector fetch:**
  - VEC_LO: address=vec.
  - VEC_HI: address=vec+1; capture rd_data as lo.
  - VEC_LD: pc_out={rd_data, lo}; pc_load=s_load=set_i=1; s_out=s.
- **Request timing:**
  - irq_n is sampled only at accept. Deassertion during a sequence has no effect.
  - boundary/brk_req are ignored while busy.

Decomposition:
- Shared package (next to the opcode includes): state encoding localparams, kind codes, P-bit indices (NEG..CARRY), vector addresses.
- Natural sub-module: int_edge_det, holding the NMI falling-edge detector plus pending latch with set-priority over clear.
- The remaining FSM and datapath stay in int_seq.

Test Plan:
- **Reset:** release reset with s_in=8'hFD; memory FFFC=34, FFFD=12 -> we never asserted; pc_out=16'h1234, s_out=8'hFA, kind=0, pc_load on the 6th cycle after release.
- **IRQ:** irq_n=0, irq_mask=0, boundary, pc_in=16'hC012, p_in=8'h81, s_in=8'hFF -> writes 01FF=C0, 01FE=12, 01FD=A1; vector from FFFE/FFFF; s_out=8'hFC.
- **Masked IRQ and BRK:** irq_mask=1 with irq_n=0 and boundary -> stays IDLE, busy=0. Same cycle with brk_req=1, p_in=8'h00 -> pushed P=8'h30, kind=3.
- **NMI priority:** NMI edge plus IRQ at the same boundary -> kind=1, vector FFFA. IRQ still pending afterwards is accepted at the next boundary.
- **Hijack:** BRK accepted, NMI edge during PUSH_PCL -> pushed P has B=1; vector fetched from FFFA/FFFB; nmi_pending=0 after.
- **Wrap and abort:** s_in=8'h01 -> pushes to 0101, 0100, 01FF; s_out=8'hFE. Separately, assert reset during VEC_HI -> busy=1, state IDLE, no pc_load; reset sequence runs after release.
